// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the RV32I pipeline control logic.
//   - hz_state_t  : hazard controller FSM states (RUN, MEM_WAIT, MEM_ERR)
//   - FWD_*       : EX-stage ALU operand forwarding selects
//   - RESULT_LOAD : ResultSrc encoding that marks a load instruction
//   - REG_W       : register-index width
//   - WAIT_W      : width of the memory wait counter
// ---------------------------------------------------------------------------
package core_pkg;

  localparam int REG_W  = 5;
  localparam int WAIT_W = 8;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    MEM_ERR  = 2'b10
  } hz_state_t;

  // True when a producer in a later stage writes a real (non-x0) register
  // that matches the requested source register.
  function automatic logic reg_match(input logic             wr_en,
                                     input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] rs);
    return wr_en && (rd != '0) && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd.sv
// ---------------------------------------------------------------------------
// fwd_unit
// Combinational forwarding select for one EX-stage ALU operand.
// Ports:
//   rs           in  5  source register of the operand in EX
//   rd_m, rd_w   in  5  destination registers in MEM and WB
//   reg_write_m  in  1  MEM stage writes the register file
//   reg_write_w  in  1  WB stage writes the register file
//   fwd          out 2  FWD_MEM / FWD_WB / FWD_RF
// ---------------------------------------------------------------------------
module fwd_unit
  import core_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rd_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  output logic [1:0]       fwd
);

  // MEM holds the younger result, so it wins over WB when both match.
  always_comb begin
    fwd = FWD_RF;
    if (reg_match(reg_write_m, rd_m, rs)) begin
      fwd = FWD_MEM;
    end else if (reg_match(reg_write_w, rd_w, rs)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline controller for the 5-stage RV32I core: load-use stalls, branch
// flushes, EX-stage forwarding and a freeze FSM for slow data-memory
// accesses with a timeout into a sticky error state.
//
// Optional feature macro: HAZARD_PERF_EN (performance counters). When it is
// not defined the counter ports stay but are tied to zero.
//
// Parameters:
//   MEM_TIMEOUT  max consecutive MEM_WAIT cycles before MEM_ERR (1..255)
//   CNT_W        performance counter width
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   Rs1D, Rs2D                         source registers in ID
//   Rs1E, Rs2E, RdE                    source/dest registers in EX
//   ResultSrcE                         2'b01 = load in EX
//   PCSrcE                             taken branch/jump resolved in EX
//   RdM, RdW, RegWriteM, RegWriteW     MEM/WB destination and write enable
//   MemReqM, MemReadyM                 data-memory request / completion
//   StallF, StallD, StallE, StallM     hold PC / IF-ID / ID-EX / EX-MEM
//   FlushD, FlushE, FlushW             clear IF-ID / ID-EX / MEM-WB
//   ForwardAE, ForwardBE               ALU operand select (00 RF,01 WB,10 MEM)
//   MemErr                             sticky memory-timeout flag
//   StallCycles, FlushEvents,
//   MemWaitCycles                      performance counters
// ---------------------------------------------------------------------------
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushEvents,
  output logic [CNT_W-1:0] MemWaitCycles
);

  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

  hz_state_t         state, state_next;
  logic [WAIT_W-1:0] wcnt, wcnt_next;
  logic              mem_err;
  logic              set_err;
  logic              freeze;
  logic              lw_stall;
  logic [1:0]        fwd_a, fwd_b;

  fwd_unit u_fwd_a (
    .rs          (Rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_a)
  );

  fwd_unit u_fwd_b (
    .rs          (Rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      state <= state_next;
      wcnt  <= wcnt_next;
      if (set_err) begin
        mem_err <= 1'b1;
      end
    end
  end

  // A load in EX whose destination is read by the instruction in ID.
  always_comb begin
    lw_stall = (ResultSrcE == RESULT_LOAD) && (RdE != '0) &&
               ((Rs1D == RdE) || (Rs2D == RdE));
  end

  // Freeze is Mealy: the very first cycle of a slow access already holds
  // the pipeline, before the FSM has moved to MEM_WAIT. A ready that
  // coincides with the timeout cycle completes the access normally.
  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    set_err    = 1'b0;
    freeze     = 1'b0;
    case (state)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          freeze     = 1'b1;
          state_next = MEM_WAIT;
          wcnt_next  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          state_next = RUN;
          wcnt_next  = '0;
        end else begin
          freeze = 1'b1;
          if (wcnt == TIMEOUT_CNT) begin
            state_next = MEM_ERR;
            set_err    = 1'b1;
          end else begin
            wcnt_next = wcnt + WAIT_W'(1);
          end
        end
      end
      MEM_ERR: begin
        state_next = MEM_ERR;
      end
      default: begin
        state_next = RUN;
        wcnt_next  = '0;
      end
    endcase
    if (reset) begin
      freeze = 1'b0;
    end
  end

  // Reset forces a clean pipeline; the error state keeps the front end
  // parked and keeps bubbles flowing into EX and WB. While frozen, a pending
  // branch in EX is deliberately ignored so it resolves once the freeze ends.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = fwd_a;
    ForwardBE = fwd_b;
    if (reset) begin
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b1;
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
    end else if (state == MEM_ERR) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (freeze) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = lw_stall;
      StallD = lw_stall;
      FlushD = PCSrcE;
      FlushE = lw_stall | PCSrcE;
    end
  end

  assign MemErr = mem_err;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;

  // Counters wrap naturally at 2^CNT_W; reset cycles are never counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (StallF) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (FlushE) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
      if (freeze) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

  assign StallCycles   = stall_cnt;
  assign FlushEvents   = flush_cnt;
  assign MemWaitCycles = wait_cnt;
`else
  assign StallCycles   = '0;
  assign FlushEvents   = '0;
  assign MemWaitCycles = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline controller for the 5-stage RV32I core. It drives the stall, flush and freeze controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the EX-stage forwarding selects.
- Resolves load-use hazards and taken branches/jumps. An FSM handles multi-cycle data-memory accesses through a req/ready handshake, with a timeout to a sticky error state.

Parameters:
- MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before entering MEM_ERR (range 1..255)
- CNT_W, 32, width of performance counters (used only with HAZARD_PERF_EN)

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- Rs1D, Rs2D  in  5 each  source registers in ID
- Rs1E, Rs2E, RdE  in  5 each  source/dest registers in EX
- ResultSrcE  in  2  2'b01 = load in EX
- PCSrcE  in  1  taken branch or jump resolved in EX
- RdM, RdW  in  5 each  dest registers in MEM/WB
- RegWriteM, RegWriteW  in  1 each  register-write enables in MEM/WB
- MemReqM  in  1  data-memory access active in MEM
- MemReadyM  in  1  data memory completes the access this cycle
- StallF, StallD, StallE, StallM  out  1 each  hold PC / IF-ID / ID-EX / EX-MEM
- FlushD, FlushE, FlushW  out  1 each  clear IF-ID / ID-EX / MEM-WB (drives clr)
- ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 = RF, 01 = WB result, 10 = MEM ALU result
- MemErr  out  1  sticky memory-timeout flag
- StallCycles, FlushEvents, MemWaitCycles  out  CNT_W each  performance counters

Behaviour:
- Registered state: fsm (RUN, MEM_WAIT, MEM_ERR), wait counter wcnt (8 b), MemErr, perf counters. All other outputs are combinational from state and inputs.
- Reset: fsm=RUN, wcnt=0, MemErr=0, counters=0. While reset=1: FlushD=FlushE=FlushW=1, all Stall*=0, Forward*=00.
- Forwarding, all states:
  - ForwardAE=10 if RegWriteM && RdM!=0 && Rs1E==RdM.
  - Else 01 if RegWriteW && RdW!=0 && Rs1E==RdW.
  - Else 00.
  - ForwardBE is identical using Rs2E. MEM has priority over WB.
- lwStall = (ResultSrcE==2'b01) && RdE!=0 && (Rs1D==RdE || Rs2D==RdE).
- freeze = (fsm==RUN && MemReqM && !MemReadyM) || (fsm==MEM_WAIT && !MemReadyM). This is Mealy: the freeze asserts in the first cycle of a slow access.
- freeze=1:
  - StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
  - Overrides lwStall and PCSrcE. A pending branch is held frozen in EX and takes effect after the freeze ends.
- freeze=0 in RUN or MEM_WAIT:
  - StallF=StallD=lwStall.
  - FlushD=PCSrcE.
  - FlushE=lwStall|PCSrcE.
  - StallE=StallM=FlushW=0.
- Transitions:
  - RUN -> MEM_WAIT when MemReqM && !MemReadyM; wcnt<=1.
  - MEM_WAIT -> RUN when MemReadyM; wcnt<=0. The pipeline advances in that same cycle.
  - MEM_WAIT, !MemReadyM: wcnt<=wcnt+1.
  - MEM_WAIT -> MEM_ERR when wcnt==MEM_TIMEOUT && !MemReadyM; MemErr<=1.
  - MemReadyM in the same cycle as the timeout wins: go to RUN, no error.
- MEM_ERR:
  - Absorbing until reset.
  - StallF=StallD=1, FlushE=1, FlushW=1, StallE=StallM=0, FlushD=0, MemErr=1.
- Reset mid-MEM_WAIT: returns to RUN next edge; the outstanding access is abandoned.
- MemReadyM while MemReqM=0 in RUN: ignored.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - StallCycles increments each cycle StallF=1.
  - FlushEvents increments each cycle FlushE=1 while not in reset.
  - MemWaitCycles increments each cycle freeze=1.
  - All counters wrap at 2^CNT_W.
- Undefined: ports remain and are tied to 0; no counter flops are inferred.

Decomposition:
- Shared package core_pkg:
  - FSM state enum.
  - Forward select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - RESULT_LOAD=2'b01.
  - Register-index width constant 5.
- Sub-module fwd_unit: combinational forwarding for one operand, instantiated twice (A, B).

Test Plan:
- Load-use: ResultSrcE=01, RdE=5, Rs1D=5 -> StallF=StallD=1, FlushE=1 for exactly 1 cycle; next cycle Rs1E=5 with RdW=5, RegWriteW=1 -> ForwardAE=01.
- Double forward: RdM=RdW=7, both RegWrite=1, Rs2E=7 -> ForwardBE=10. Repeat with RdM=RdW=0 -> ForwardBE=00.
- Branch: PCSrcE=1, no load -> FlushD=FlushE=1, no stalls. Branch plus lwStall together -> FlushE=1, StallD=1.
- Slow memory: MemReqM=1, MemReadyM low for 3 cycles then high -> freeze 3 cycles, FlushW=1 each, FSM back in RUN. With HAZARD_PERF_EN, MemWaitCycles=3.
- Timeout: MEM_TIMEOUT=4, MemReadyM never asserts -> MemErr=1 after the 5th freeze cycle, stays 1 until reset, then all outputs return to reset values.
- Reset during MEM_WAIT -> next cycle fsm=RUN, MemErr=0, counters=0.
